sum_tree_acc: RTL and testbench

Parametrised, valid-tagged pipelined adder tree with an optional frame accumulator. It reduces `N_IN` lanes of `IN_W`-bit operands to one sum per beat, with one register stage per tree level. A final stage either passes each beat's sum through or accumulates sums over a first/last-delimited frame. It sits after the per-lane product/partial-sum generators and feeds the result collector.

---
 rtl/sum_tree_acc.sv | 178 +++++++++++++++++
 tb/tb_sum_tree_acc.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_tree_acc.sv
// Pipelined, valid-tagged adder tree reducing N_IN lanes to one sum per beat,
// followed by a pass-through / frame-accumulate output stage.
module sum_tree_acc #(
   parameter int unsigned N_IN   = 64,
   parameter int unsigned IN_W   = 128,
   parameter int unsigned SIGNED = 0,
   parameter int unsigned ACC_W  = 144
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [N_IN*IN_W-1:0] in_data,
   input  logic                 in_mode,
   input  logic                 in_first,
   input  logic                 in_last,
   output logic                 out_valid,
   output logic [ACC_W-1:0]     out_data,
   output logic                 out_overflow
);

   localparam int unsigned LEVELS = $clog2(N_IN);
   localparam int unsigned TREE_W = IN_W + LEVELS;
   localparam int unsigned NPAD   = 2 ** LEVELS;
   localparam int unsigned PADW   = NPAD * IN_W;

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StAccum = 1'b1;

   // Level 0 is the zero-padded input; level k holds NPAD>>k sums of width IN_W+k.
   for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
      localparam int unsigned W     = IN_W + k;
      localparam int unsigned NODES = NPAD >> k;

      logic [NODES*W-1:0] lvl_sum;
      logic               lvl_vld;
      logic               lvl_mode;
      logic               lvl_first;
      logic               lvl_last;

      if (k == 0) begin : g_in
         assign lvl_sum   = PADW'(in_data);
         assign lvl_vld   = in_valid;
         assign lvl_mode  = in_mode;
         assign lvl_first = in_first;
         assign lvl_last  = in_last;
      end else begin : g_add
         localparam int unsigned WP = W - 1;

         logic [NODES*W-1:0] sum_d;

         always_comb begin
            logic [WP-1:0] a, b;
            logic          sa, sb;
            sum_d = '0;
            for (int n = 0; n < NODES; n++) begin
               a  = g_lvl[k-1].lvl_sum[2*n*WP +: WP];
               b  = g_lvl[k-1].lvl_sum[(2*n+1)*WP +: WP];
               sa = (SIGNED != 0) && a[WP-1];
               sb = (SIGNED != 0) && b[WP-1];
               sum_d[n*W +: W] = {sa, a} + {sb, b};
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               lvl_sum   <= '0;
               lvl_vld   <= 1'b0;
               lvl_mode  <= 1'b0;
               lvl_first <= 1'b0;
               lvl_last  <= 1'b0;
            end else begin
               lvl_vld <= g_lvl[k-1].lvl_vld;
               if (g_lvl[k-1].lvl_vld) begin
                  lvl_sum   <= sum_d;
                  lvl_mode  <= g_lvl[k-1].lvl_mode;
                  lvl_first <= g_lvl[k-1].lvl_first;
                  lvl_last  <= g_lvl[k-1].lvl_last;
               end
            end
         end
      end
   end

   logic [TREE_W-1:0] tree_sum;
   logic              t_vld, t_mode, t_first, t_last;

   assign tree_sum = g_lvl[LEVELS].lvl_sum;
   assign t_vld    = g_lvl[LEVELS].lvl_vld;
   assign t_mode   = g_lvl[LEVELS].lvl_mode;
   assign t_first  = g_lvl[LEVELS].lvl_first;
   assign t_last   = g_lvl[LEVELS].lvl_last;

   logic [0:0]       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             flag_q, flag_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] out_data_q, out_data_d;
   logic             out_ovf_q, out_ovf_d;

   logic [ACC_W-1:0] t_ext;
   logic [ACC_W:0]   add_full;
   logic             add_ovf;

   always_comb begin
      if (SIGNED != 0) begin
         t_ext = ACC_W'($signed(tree_sum));
      end else begin
         t_ext = ACC_W'(tree_sum);
      end
   end

   assign add_full = {1'b0, acc_q} + {1'b0, t_ext};

   // Signed: operands agree in sign but the wrapped result does not.
   always_comb begin
      if (SIGNED != 0) begin
         add_ovf = (acc_q[ACC_W-1] == t_ext[ACC_W-1]) &&
                   (add_full[ACC_W-1] != acc_q[ACC_W-1]);
      end else begin
         add_ovf = add_full[ACC_W];
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      flag_d      = flag_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_ovf_d   = out_ovf_q;
      if (t_vld) begin
         if (!t_mode) begin
            out_valid_d = 1'b1;
            out_data_d  = t_ext;
            out_ovf_d   = 1'b0;
         end else begin
            if (t_first || (state_q == StIdle)) begin
               acc_d  = t_ext;
               flag_d = 1'b0;
            end else begin
               acc_d  = add_full[ACC_W-1:0];
               flag_d = flag_q | add_ovf;
            end
            if (t_last) begin
               out_valid_d = 1'b1;
               out_data_d  = acc_d;
               out_ovf_d   = flag_d;
               state_d     = StIdle;
            end else begin
               state_d = StAccum;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         flag_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         flag_q      <= flag_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_sum_tree_acc.sv
// Three sum_tree_acc instances share one stimulus stream; a queue-based scoreboard per
// instance is fed by an arithmetic reference model and drained by a negedge monitor.
module tb_sum_tree_acc;

   localparam int NA = 64;
   localparam int WA = 128;

   typedef logic [159:0]    w_t;
   typedef logic [NA*WA-1:0] d_t;
   typedef struct {
      w_t data;
      bit ovf;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic in_valid = 1'b0;
   logic in_mode = 1'b0;
   logic in_first = 1'b0;
   logic in_last = 1'b0;
   d_t   in_data = '0;

   logic         ov_a, ov_b, ov_c;
   logic [143:0] od_a;
   logic [133:0] od_b;
   logic [10:0]  od_c;
   logic         of_a, of_b, of_c;

   always #5 clk = ~clk;

   sum_tree_acc #(.N_IN(64), .IN_W(128), .SIGNED(0), .ACC_W(144)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_mode(in_mode),
      .in_first(in_first), .in_last(in_last), .out_valid(ov_a), .out_data(od_a),
      .out_overflow(of_a)
   );

   sum_tree_acc #(.N_IN(64), .IN_W(128), .SIGNED(0), .ACC_W(134)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_mode(in_mode),
      .in_first(in_first), .in_last(in_last), .out_valid(ov_b), .out_data(od_b),
      .out_overflow(of_b)
   );

   sum_tree_acc #(.N_IN(5), .IN_W(8), .SIGNED(1), .ACC_W(11)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data[39:0]),
      .in_mode(in_mode), .in_first(in_first), .in_last(in_last), .out_valid(ov_c),
      .out_data(od_c), .out_overflow(of_c)
   );

   int pn[3]   = '{64, 64, 5};
   int pw[3]   = '{128, 128, 8};
   int pa[3]   = '{144, 134, 11};
   bit ps[3]   = '{1'b0, 1'b0, 1'b1};
   int plat[3] = '{7, 7, 4};

   exp_t exq[3][$];
   w_t   m_acc[3];
   bit   m_ovf[3];
   bit   m_open[3];
   w_t   last_d[3];
   bit   last_o[3];

   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input w_t act, input w_t exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic w_t msk(input int w);
      return (w_t'(1) << w) - w_t'(1);
   endfunction

   // Zero- or sign-extend a w-bit value to the full model width.
   function automatic w_t ext(input w_t x, input int w, input bit s);
      w_t m = msk(w);
      w_t r = x & m;
      if (s && r[w-1]) r = r | ~m;
      return r;
   endfunction

   function automatic w_t tsum(input d_t d, input int i);
      w_t s = '0;
      for (int n = 0; n < pn[i]; n++) s += ext(w_t'(d >> (n * pw[i])), pw[i], ps[i]);
      return s & msk(pa[i]);
   endfunction

   task automatic model(input int i, input d_t d, input bit mode, input bit first,
                        input bit last);
      w_t   t = tsum(d, i);
      w_t   s;
      exp_t e;
      e.cyc = cyc + plat[i];
      if (!mode) begin
         e.data = t;
         e.ovf  = 1'b0;
         exq[i].push_back(e);
      end else begin
         if (first || !m_open[i]) begin
            m_acc[i] = t;
            m_ovf[i] = 1'b0;
         end else begin
            s = ext(m_acc[i], pa[i], ps[i]) + ext(t, pa[i], ps[i]);
            m_acc[i] = s & msk(pa[i]);
            if (ext(m_acc[i], pa[i], ps[i]) != s) m_ovf[i] = 1'b1;
         end
         if (last) begin
            e.data = m_acc[i];
            e.ovf  = m_ovf[i];
            exq[i].push_back(e);
            m_open[i] = 1'b0;
         end else begin
            m_open[i] = 1'b1;
         end
      end
   endtask

   task automatic mon(input int i, input bit v, input w_t d, input bit o);
      exp_t e;
      if (v) begin
         if (exq[i].size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_out[%0d]: got %0h, expected no output (cycle %0d)",
                     i, d, cyc);
         end else begin
            e = exq[i].pop_front();
            chk($sformatf("data[%0d]", i), d, e.data);
            chk($sformatf("ovf[%0d]", i), w_t'(o), w_t'(e.ovf));
            chk($sformatf("latency[%0d]", i), w_t'(cyc), w_t'(e.cyc));
            last_d[i] = e.data;
            last_o[i] = e.ovf;
         end
      end else begin
         chk($sformatf("hold_data[%0d]", i), d, last_d[i]);
         chk($sformatf("hold_ovf[%0d]", i), w_t'(o), w_t'(last_o[i]));
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, ov_a, w_t'(od_a), of_a);
         mon(1, ov_b, w_t'(od_b), of_b);
         mon(2, ov_c, w_t'(od_c), of_c);
      end
   end

   task automatic beat(input d_t d, input bit mode, input bit first, input bit last);
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = mode;
      in_first = first;
      in_last  = last;
      for (int i = 0; i < 3; i++) model(i, d, mode, first, last);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Idle cycle with junk sidebands and data, which must be ignored.
   task automatic idle(input int n);
      for (int c = 0; c < n; c++) begin
         in_valid = 1'b0;
         in_mode  = 1'($urandom);
         in_first = 1'($urandom);
         in_last  = 1'($urandom);
         for (int k = 0; k < NA * WA / 32; k++) in_data[k*32 +: 32] = $urandom();
         @(posedge clk);
         #1;
      end
   endtask

   function automatic d_t all_lanes(input logic [WA-1:0] v);
      d_t d;
      for (int l = 0; l < NA; l++) d[l*WA +: WA] = v;
      return d;
   endfunction

   function automatic d_t rnd_data();
      d_t d = '0;
      case ($urandom_range(0, 3))
         0: for (int k = 0; k < NA * WA / 32; k++) d[k*32 +: 32] = $urandom();
         1: d = '1;
         2: for (int l = 0; l < NA; l++) d[l*WA +: WA] = WA'($urandom_range(0, 7));
         default: begin
            for (int k = 0; k < NA * WA / 8; k++) begin
               case ($urandom_range(0, 3))
                  0: d[k*8 +: 8] = 8'h80;
                  1: d[k*8 +: 8] = 8'h7f;
                  2: d[k*8 +: 8] = 8'hff;
                  default: d[k*8 +: 8] = 8'h00;
               endcase
            end
         end
      endcase
      return d;
   endfunction

   task automatic check_reset_outputs();
      chk("rst_valid_a", w_t'(ov_a), '0);
      chk("rst_data_a", w_t'(od_a), '0);
      chk("rst_ovf_a", w_t'(of_a), '0);
      chk("rst_valid_b", w_t'(ov_b), '0);
      chk("rst_data_b", w_t'(od_b), '0);
      chk("rst_ovf_b", w_t'(of_b), '0);
      chk("rst_valid_c", w_t'(ov_c), '0);
      chk("rst_data_c", w_t'(od_c), '0);
      chk("rst_ovf_c", w_t'(of_c), '0);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 3; i++) begin
         exq[i].delete();
         m_acc[i]  = '0;
         m_ovf[i]  = 1'b0;
         m_open[i] = 1'b0;
         last_d[i] = '0;
         last_o[i] = 1'b0;
      end
   endtask

   initial begin
      d_t d;
      clear_model();
      #2 rst_n = 1'b0;
      #1 check_reset_outputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // Single pass beat of all-ones lanes.
      beat('1, 1'b0, 1'b0, 1'b0);
      idle(9);

      // Back-to-back pass beats: lane i = i, then all ones.
      for (int l = 0; l < NA; l++) d[l*WA +: WA] = WA'(l);
      beat(d, 1'b0, 1'b0, 1'b0);
      beat(all_lanes(WA'(1)), 1'b0, 1'b0, 1'b0);
      idle(9);

      // Three-beat frame with a pass beat inserted mid-frame.
      beat(all_lanes(WA'(1)), 1'b1, 1'b1, 1'b0);
      beat(all_lanes(WA'(1)), 1'b0, 1'b0, 1'b0);
      beat(all_lanes(WA'(1)), 1'b1, 1'b0, 1'b0);
      beat(all_lanes(WA'(1)), 1'b1, 1'b0, 1'b1);
      idle(9);

      // Two-beat frame of maxima (wraps the narrow accumulator), then a lone frame.
      beat('1, 1'b1, 1'b1, 1'b0);
      beat('1, 1'b1, 1'b0, 1'b1);
      beat(all_lanes(WA'(1)), 1'b1, 1'b1, 1'b1);
      idle(9);

      // All bytes 0x80: most negative signed lanes.
      beat(all_lanes({16{8'h80}}), 1'b0, 1'b0, 1'b0);
      idle(9);

      // Reset with a partial frame and a pass beat in flight.
      beat(all_lanes(WA'(5)), 1'b1, 1'b1, 1'b0);
      beat(all_lanes(WA'(5)), 1'b1, 1'b0, 1'b0);
      beat(all_lanes(WA'(3)), 1'b0, 1'b0, 1'b0);
      idle(2);
      rst_n = 1'b0;
      #1 check_reset_outputs();
      clear_model();
      @(posedge clk);
      #1 rst_n = 1'b1;
      beat(all_lanes(WA'(2)), 1'b1, 1'b1, 1'b1);
      idle(9);

      // Randomized traffic.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 9) < 7) begin
            beat(rnd_data(), $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0);
         end else begin
            idle(1);
         end
      end
      idle(15);

      for (int i = 0; i < 3; i++) chk($sformatf("drained[%0d]", i), w_t'(exq[i].size()), '0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
